fifo_uart_tx: RTL and testbench

Serial transmit stage that sits directly downstream of the `fifo` block and drains it. When the FIFO is non-empty and the block is enabled, it pops one word and shifts it out LSB-first as an asynchronous serial frame: start bit, DATA_WIDTH data bits, optional parity, one stop bit. It then repeats until the FIFO reports empty. The block owns the FIFO's `deq` input; the producer side owns `enq`.

---
 rtl/fifo_uart_tx.sv | 152 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains the upstream fifo and shifts each word out as an LSB-first UART frame.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deq,
  output logic                  tx,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, STOP
  } state_t;
`endif

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  tx_n, deq_n, busy_n;
  logic                  bit_end, go;
`ifdef UART_TX_PARITY_EN
  logic                  par, par_n;
`endif

  assign bit_end = (cnt == '0);
  assign go      = enable && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      cnt      <= '0;
      idx      <= '0;
      tx       <= 1'b1;
      fifo_deq <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      tx       <= tx_n;
      fifo_deq <= deq_n;
      busy     <= busy_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    idx_n   = idx;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: if (go) state_n = POP;
      POP:  state_n = LOAD;
      LOAD: begin
        shift_n = fifo_data;
        idx_n   = '0;
        cnt_n   = CNT_TOP;
`ifdef UART_TX_PARITY_EN
        par_n   = ^fifo_data;
`endif
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = CNT_TOP;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = CNT_TOP;
          shift_n = shift >> 1;
          idx_n   = idx + IW'(1);
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = CNT_TOP;
          state_n = STOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n   = CNT_TOP;
          state_n = go ? POP : IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the upcoming state.
  always_comb begin
    tx_n   = 1'b1;
    deq_n  = (state_n == POP);
    busy_n = (state_n != IDLE);
    unique case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural fifo in front.
// Honours UART_TX_PARITY_EN to expect the parity bit.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_deq;
  logic       tx;
  logic       busy;

  logic       enq = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;

  int n_cmp = 0;
  int n_fail = 0;
  int deq_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_deq(fifo_deq),
    .tx(tx),
    .busy(busy)
  );

  // Registered-read fifo: data_out is valid the cycle after deq.
  assign fifo_empty = (fcnt == 5'd0);
  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      fifo_data <= '0;
    end else begin
      if (enq) begin
        mem[wp] <= din;
        wp <= wp + 4'd1;
      end
      if (fifo_deq && !fifo_empty) begin
        fifo_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      fcnt <= fcnt + {4'd0, enq} - {4'd0, fifo_deq && !fifo_empty};
    end
  end

  always @(negedge clk) if (fifo_deq === 1'b1) deq_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    enq = 1'b1;
    din = w;
    @(negedge clk);
    enq = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] w, input logic [9:0] fr,
                             input logic par, input int exp_wait, input string nm);
    int n;
    logic bad, busy_bad, eb;
    logic [7:0] got;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 200);
    if (tx !== 1'b0) begin
      cmp({nm, " start_timeout"}, 32'(tx), 32'd0);
      return;
    end
    if (exp_wait > 0) cmp({nm, " start_delay"}, 32'(n), 32'(exp_wait));
    busy_bad = 1'b0;
    got = '0;
    for (int b = 0; b < NB; b++) begin
      if (PAR && b == 9) eb = par;
      else if (b < 10) eb = fr[b];
      else eb = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx !== eb) bad = 1'b1;
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (c == CPB / 2 && b >= 1 && b <= 8) got[b-1] = tx;
      end
      cmp($sformatf("%s bit%0d", nm, b), 32'(bad ? ~eb : eb), 32'(eb));
    end
    cmp({nm, " busy_in_frame"}, 32'(busy_bad), 32'd0);
    cmp({nm, " decoded"}, 32'(got), 32'(w));
  endtask

  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;
    logic       par;
    logic       queued;
    int         gap;
  } vec_t;

  vec_t vec [5];

  initial begin
    int d0;
    logic bad;
    vec[0] = '{8'hA5, 10'h34A, 1'b0, 1'b0, 3};
    vec[1] = '{8'h00, 10'h200, 1'b0, 1'b0, 3};
    vec[2] = '{8'hFF, 10'h3FE, 1'b0, 1'b1, 3};
    vec[3] = '{8'h3C, 10'h278, 1'b0, 1'b1, 3};
    vec[4] = '{8'h07, 10'h20E, 1'b1, 1'b0, 3};

    repeat (3) @(negedge clk);
    cmp("reset tx", 32'(tx), 32'd1);
    cmp("reset deq", 32'(fifo_deq), 32'd0);
    cmp("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    fifo_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (!vec[i].queued) begin
        enable = 1'b0;
        push(vec[i].word);
        for (int j = i + 1; j < 5 && vec[j].queued; j++) push(vec[j].word);
        enable = 1'b1;
      end
      check_frame(vec[i].word, vec[i].frame, vec[i].par, vec[i].gap,
                  $sformatf("vec%0d", i));
      if (i == 4 || !vec[i+1].queued) begin
        @(negedge clk);
        cmp($sformatf("vec%0d busy_fall", i), 32'(busy), 32'd0);
        cmp($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'd1);
      end
    end
    cmp("table deq pulses", 32'(deq_cnt), 32'd5);

    // Reset in the middle of data bit 3 with another word waiting.
    d0 = deq_cnt;
    enable = 1'b0;
    push(8'h55);
    push(8'h66);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst start", 32'(tx), 32'd0);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cmp("rst tx", 32'(tx), 32'd1);
    cmp("rst busy", 32'(busy), 32'd0);
    cmp("rst deq", 32'(fifo_deq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_frame(8'h66, 10'h2CC, 1'b0, 3, "after_rst");
    @(negedge clk);
    cmp("rst busy_fall", 32'(busy), 32'd0);
    cmp("rst deq pulses", 32'(deq_cnt - d0), 32'd2);
    cmp("rst empty", 32'(fifo_empty), 32'd1);

    // Enable dropped mid-frame with two words still queued.
    d0 = deq_cnt;
    enable = 1'b0;
    push(8'h81);
    push(8'h42);
    push(8'h24);
    enable = 1'b1;
    fork
      begin
        repeat (20) @(negedge clk);
        enable = 1'b0;
      end
    join_none
    check_frame(8'h81, 10'h302, 1'b0, 3, "gate0");
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_deq !== 1'b0) bad = 1'b1;
    end
    cmp("gate idle", 32'(bad), 32'd0);
    cmp("gate deq pulses", 32'(deq_cnt - d0), 32'd1);
    enable = 1'b1;
    check_frame(8'h42, 10'h284, 1'b0, 3, "gate1");
    check_frame(8'h24, 10'h248, 1'b0, 3, "gate2");
    @(negedge clk);
    cmp("gate busy_fall", 32'(busy), 32'd0);
    cmp("gate deq total", 32'(deq_cnt - d0), 32'd3);

    // Empty fifo while enabled must stay idle.
    d0 = deq_cnt;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_deq !== 1'b0) bad = 1'b1;
    end
    cmp("empty idle", 32'(bad), 32'd0);
    cmp("empty deq", 32'(deq_cnt - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
